sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out stage directly downstream of the D flip-flop. It consumes the flop's registered Q as a bit stream and assembles WIDTH-bit words.
- Each frame is started by a START marker and gated by a per-bit EN strobe.
- The finished word is presented on a VALID/READY output port with a one-word holding register and a sticky overrun flag.

Parameters:
- WIDTH, 8: bits per frame, legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in Q[WIDTH-1]; 0 = first bit lands in Q[0].

Ports:
- C, input, 1: clock; all state updates on the rising edge.
- nR, input, 1: asynchronous active-low reset.
- D, input, 1: serial data bit, the Q output of the upstream D flip-flop.
- EN, input, 1: bit strobe; D is sampled only on edges where EN=1.
- START, input, 1: frame-start marker, coincident with bit 0 of the frame.
- READY, input, 1: downstream accepts the word on an edge where VALID=1 and READY=1.
- CLR_OVR, input, 1: synchronous clear of OVR.
- Q, output, WIDTH: assembled word, stable while VALID=1.
- VALID, output, 1: Q holds an unconsumed word.
- OVR, output, 1: sticky flag, set when a completed word was dropped.
- BUSY, output, 1: a frame is in progress (state SHIFT).

Behaviour:
- Reset (nR=0, asynchronous):
  - Q=0, VALID=0, OVR=0, BUSY=0.
  - Shift register=0, bit counter=0, state=IDLE.
  - Takes effect mid-frame; the partial frame is discarded.
  - First active edge is the first rising C after nR deasserts.
- State machine, 2 states:
  - IDLE: EN without START is ignored. START=1 with EN=1: sample D as bit 0, counter=1, go to SHIFT. START=1 with EN=0: ignored.
  - SHIFT: on EN=1, sample D and increment the counter.
  - Frame completion: when EN=1 and counter==WIDTH-1, the sampled bit completes the word; go to IDLE and counter=0.
  - START=1 with EN=1 in SHIFT: partial frame discarded, D taken as new bit 0, counter=1, stay in SHIFT.
  - EN=0 in SHIFT: hold; no timeout.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit into LSB.
  - MSB_FIRST=0: shift right, new bit into MSB.
  - After WIDTH bits, the first bit therefore sits at Q[WIDTH-1] or Q[0] respectively.
- Latency: the completed word appears on Q with VALID=1 on the same edge that samples the last bit, i.e. visible one cycle after that EN cycle begins.
- Output handshake:
  - VALID=1 and READY=1 on an edge: the word is consumed and VALID falls, unless a new word completes on the same edge.
  - Completion and consumption on the same edge: Q takes the new word, VALID stays 1, OVR unchanged.
  - Completion while VALID=1 and READY=0: the new word is dropped, Q and VALID are unchanged, OVR=1.
  - OVR is cleared only by reset or CLR_OVR=1. If CLR_OVR and a new overrun occur on the same edge, the overrun wins and OVR stays 1.
  - Q holds its last value after consumption (VALID=0); it is not zeroed.
- BUSY = (state==SHIFT), registered.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1; wrap is by explicit reset to 0, never by overflow.

Decomposition:
- Shared package/header (deser_pkg):
  - DESER_WIDTH_DEFAULT=8.
  - State encoding ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Function cnt_w(WIDTH) = $clog2(WIDTH).
- One natural sub-module, deser_out_reg: the VALID/READY holding register with overrun logic. Inputs word_in and word_done; outputs Q, VALID, OVR.
- Shift register, counter and FSM stay in the top level.

Test Plan:
- WIDTH=8, MSB_FIRST=1: START+EN with D=1, then EN for bits 0,1,0,0,1,0,1, READY=1 -> Q=8'hA5 with VALID=1 for exactly 1 cycle, OVR=0, BUSY falls on the same edge.
- Same bits with MSB_FIRST=0 -> Q=8'hA5 bit-reversed = 8'hA5 (palindrome). Repeat with bits 1,1,0,0,0,0,0,0 -> MSB_FIRST=1 gives 8'hC0, MSB_FIRST=0 gives 8'h03.
- READY=0: frame 8'h3C completes, then frame 8'hFF completes -> Q stays 8'h3C, VALID=1, OVR=1. Then CLR_OVR=1 -> OVR=0. Then READY=1 -> VALID=0.
- VALID=1 with Q=8'h11, and READY=1 on the same edge that frame 8'h22 completes -> Q=8'h22, VALID stays 1, OVR=0.
- START+EN after 5 bits of a frame, then 8 clean bits 8'h5A -> only 8'h5A delivered; the partial frame produces no VALID.
- nR pulsed low asynchronously (between edges) after 4 bits with VALID=1 -> all outputs 0 immediately. A subsequent full frame 8'h81 -> Q=8'h81, VALID=1.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
//   DESER_WIDTH_DEFAULT : default frame width in bits
//   state_e             : frame FSM state encoding (IDLE / SHIFT)
//   cnt_w()             : bit-counter width for a given frame width
package deser_pkg;

  localparam int unsigned DESER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// One-word VALID/READY holding register with sticky overrun flag.
// Ports:
//   C, nR      : clock (rising edge), async active-low reset
//   word_in    : freshly completed word
//   word_done  : word_in is valid this cycle
//   READY      : downstream accepts the held word when VALID=1
//   CLR_OVR    : synchronous clear of OVR (a same-edge overrun wins)
//   Q, VALID   : held word and its valid flag
//   OVR        : sticky flag, a completed word was dropped
module deser_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             C,
  input  logic             nR,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_done,
  input  logic             READY,
  input  logic             CLR_OVR,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             OVR
);

  logic [WIDTH-1:0] q_q;
  logic             valid_q;
  logic             ovr_q;
  logic             accept;
  logic             drop;

  // A new word is taken if the slot is empty or is being drained on this edge.
  always_comb begin
    accept = word_done && (!valid_q || READY);
    drop   = word_done && valid_q && !READY;
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (accept) begin
        q_q     <= word_in;
        valid_q <= 1'b1;
      end else if (valid_q && READY) begin
        // Q keeps its last value after consumption
        valid_q <= 1'b0;
      end

      if (drop) begin
        ovr_q <= 1'b1;
      end else if (CLR_OVR) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign Q     = q_q;
  assign VALID = valid_q;
  assign OVR   = ovr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer fed by an upstream D flip-flop.
// Frames start with START (coincident with bit 0) and advance on EN strobes;
// the finished WIDTH-bit word is handed to a VALID/READY holding register.
// Ports:
//   C, nR   : clock (rising edge), async active-low reset
//   D       : serial data bit, sampled only when EN=1
//   EN      : bit strobe
//   START   : frame-start marker (restarts any partial frame)
//   READY   : downstream accept
//   CLR_OVR : synchronous clear of OVR
//   Q       : assembled word, stable while VALID=1
//   VALID   : Q holds an unconsumed word
//   OVR     : sticky overrun flag
//   BUSY    : a frame is in progress
module sipo_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DESER_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             nR,
  input  logic             D,
  input  logic             EN,
  input  logic             START,
  input  logic             READY,
  input  logic             CLR_OVR,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             OVR,
  output logic             BUSY
);

  localparam int unsigned     CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q;
  logic             word_done;

  // MSB-first shifts left with the new bit in the LSB; LSB-first shifts right
  // with the new bit in the MSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic              bit_i);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], bit_i};
    end else begin
      return {bit_i, cur[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;

    if (EN) begin
      if (START) begin
        // START+EN always opens a fresh frame, discarding any partial one
        sr_d    = shift_in('0, D);
        cnt_d   = CW'(1);
        state_d = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        sr_d = shift_in(sr_q, D);
        if (cnt_q == LAST) begin
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_SHIFT);
    end
  end

  assign BUSY = busy_q;

  // The completed word is the shift-register next value, so it lands in the
  // holding register on the same edge that samples the last bit.
  deser_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .C         (C),
    .nR        (nR),
    .word_in   (sr_d),
    .word_done (word_done),
    .READY     (READY),
    .CLR_OVR   (CLR_OVR),
    .Q         (Q),
    .VALID     (VALID),
    .OVR       (OVR)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first
// instance share all inputs; expected words are hand-computed constants.
module tb_sipo_deserializer;

  logic       C       = 1'b0;
  logic       nR      = 1'b0;
  logic       D       = 1'b0;
  logic       EN      = 1'b0;
  logic       START   = 1'b0;
  logic       READY   = 1'b0;
  logic       CLR_OVR = 1'b0;

  logic [7:0] Qm, Ql;
  logic       Vm, Vl, Om, Ol, Bm, Bl;

  int tests = 0;
  int fails = 0;

  always #5 C = ~C;

  sipo_deserializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut_m (
    .C       (C),
    .nR      (nR),
    .D       (D),
    .EN      (EN),
    .START   (START),
    .READY   (READY),
    .CLR_OVR (CLR_OVR),
    .Q       (Qm),
    .VALID   (Vm),
    .OVR     (Om),
    .BUSY    (Bm)
  );

  sipo_deserializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) dut_l (
    .C       (C),
    .nR      (nR),
    .D       (D),
    .EN      (EN),
    .START   (START),
    .READY   (READY),
    .CLR_OVR (CLR_OVR),
    .Q       (Ql),
    .VALID   (Vl),
    .OVR     (Ol),
    .BUSY    (Bl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] qm, input logic [7:0] ql,
                           input logic v, input logic o, input logic b);
    chk({tag, "_Qmsb"},  32'(Qm), 32'(qm));
    chk({tag, "_Qlsb"},  32'(Ql), 32'(ql));
    chk({tag, "_Vmsb"},  32'(Vm), 32'(v));
    chk({tag, "_Vlsb"},  32'(Vl), 32'(v));
    chk({tag, "_OVRmsb"}, 32'(Om), 32'(o));
    chk({tag, "_OVRlsb"}, 32'(Ol), 32'(o));
    chk({tag, "_BUSYmsb"}, 32'(Bm), 32'(b));
    chk({tag, "_BUSYlsb"}, 32'(Bl), 32'(b));
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic send_bit(input logic st, input logic d);
    START = st;
    D     = d;
    EN    = 1'b1;
    step();
    EN    = 1'b0;
    START = 1'b0;
  endtask

  // Sends the first n bits of b, MSB of b first, START on the first one.
  task automatic send_partial(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(i == 0, b[7-i]);
  endtask

  task automatic send_rest(input logic [7:0] b, input int done);
    for (int i = done; i < 8; i++) send_bit(1'b0, b[7-i]);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_partial(b, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge C);
    nR = 1'b1;

    // EN without START, and START without EN, are ignored in IDLE
    D = 1'b1; EN = 1'b1; step(); EN = 1'b0;
    check_all("en_only", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    START = 1'b1; step(); START = 1'b0;
    check_all("start_only", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    READY = 1'b1;
    send_partial(8'hA5, 1);
    check_all("a5_bit0", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    send_rest(8'hA5, 1);
    check_all("a5", 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
    step();
    check_all("a5_taken", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);

    send_frame(8'hC0);
    check_all("c0", 8'hC0, 8'h03, 1'b1, 1'b0, 1'b0);
    step();
    check_all("c0_taken", 8'hC0, 8'h03, 1'b0, 1'b0, 1'b0);

    // Overrun: second word dropped while the first is held
    READY = 1'b0;
    send_frame(8'h3C);
    check_all("3c", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF);
    check_all("ovr", 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0);
    CLR_OVR = 1'b1; step(); CLR_OVR = 1'b0;
    check_all("clr_ovr", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
    READY = 1'b1; step();
    check_all("drain", 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Completion and consumption on the same edge
    READY = 1'b0;
    send_frame(8'h11);
    check_all("11", 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
    send_partial(8'h22, 7);
    READY = 1'b1;
    send_rest(8'h22, 7);
    check_all("22_swap", 8'h22, 8'h44, 1'b1, 1'b0, 1'b0);
    step();
    check_all("22_taken", 8'h22, 8'h44, 1'b0, 1'b0, 1'b0);

    // Restart mid-frame: partial frame never produces VALID
    send_partial(8'hFF, 5);
    check_all("partial", 8'h22, 8'h44, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A);
    check_all("5a", 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0);
    step();
    check_all("5a_taken", 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Overrun beats CLR_OVR on the same edge
    READY = 1'b0;
    send_frame(8'h3C);
    send_partial(8'hFF, 7);
    CLR_OVR = 1'b1;
    send_rest(8'hFF, 7);
    CLR_OVR = 1'b0;
    check_all("ovr_wins", 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges, mid-frame, with VALID=1
    send_partial(8'h81, 4);
    check_all("pre_rst", 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1);
    #2;
    nR = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    nR = 1'b1;

    // Full frame after reset, with EN gaps held in SHIFT
    send_partial(8'h81, 4);
    step();
    step();
    check_all("hold", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    send_rest(8'h81, 4);
    check_all("81", 8'h81, 8'h81, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
